// File: rtl/char_scroller.sv
// Rotating four-character 7-segment display stage with prescaled auto-rotation
// and edge-detected manual stepping.
module char_scroller #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] C0,
  input  logic [1:0] C1,
  input  logic [1:0] C2,
  input  logic [1:0] C3,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [1:0] sel,
  output logic       tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          step_q;
  logic [1:0]    offset, offset_nxt;
  logic [7:0]    chars;
  logic          stp, adv;
  logic [6:0]    hex_nxt [4];

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] enc(input logic [1:0] code);
    case (code)
      2'b00:   enc = 7'b0100001;
      2'b01:   enc = 7'b0000110;
      2'b10:   enc = 7'b1111001;
      default: enc = SEG_OFF;
    endcase
  endfunction

  assign chars = {C3, C2, C1, C0};
  assign stp   = step & ~step_q;
  assign adv   = (run & tick) | (~run & stp);
  assign sel   = offset;

  // Next state, next offset and next segment patterns
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    for (int k = 0; k < 4; k++) hex_nxt[k] = SEG_OFF;
    case (state)
      BLANK: begin
        offset_nxt = 2'd0;
        if (run | stp) state_nxt = SHOW;
      end
      SHOW: begin
        if (adv) offset_nxt = dir ? offset - 2'd1 : offset + 2'd1;
        // HEXk shows C[(k - offset) mod 4], so a rising offset scrolls text left
        for (int k = 0; k < 4; k++)
          hex_nxt[k] = enc(chars[{2'(k) - offset, 1'b0} +: 2]);
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= BLANK;
      offset <= 2'd0;
      cnt    <= '0;
      tick   <= 1'b0;
      step_q <= 1'b0;
      HEX0   <= SEG_OFF;
      HEX1   <= SEG_OFF;
      HEX2   <= SEG_OFF;
      HEX3   <= SEG_OFF;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      step_q <= step;
      if (run) begin
        cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        tick <= (cnt == CNT_MAX);
      end else begin
        cnt  <= '0;
        tick <= 1'b0;
      end
      HEX0 <= hex_nxt[0];
      HEX1 <= hex_nxt[1];
      HEX2 <= hex_nxt[2];
      HEX3 <= hex_nxt[3];
    end
  end

endmodule

// File: tb/tb_char_scroller.sv
// Directed self-checking bench for char_scroller with TICK_DIV=4.
module tb_char_scroller;

  localparam logic [6:0] S_D   = 7'b0100001;
  localparam logic [6:0] S_E   = 7'b0000110;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_OFF = 7'b1111111;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] C0, C1, C2, C3;
  logic       run, step, dir;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [1:0] sel;
  logic       tick;

  int checks = 0;
  int errors = 0;

  char_scroller #(.TICK_DIV(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .C0(C0), .C1(C1), .C2(C2), .C3(C3),
    .run(run), .step(step), .dir(dir),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .sel(sel), .tick(tick)
  );

  always #5 Clock = ~Clock;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_hex3"}, HEX3, e3);
    check({tag, "_hex2"}, HEX2, e2);
    check({tag, "_hex1"}, HEX1, e1);
    check({tag, "_hex0"}, HEX0, e0);
  endtask

  initial begin
    Reset = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;
    C3 = 2'b00; C2 = 2'b01; C1 = 2'b10; C0 = 2'b11;
    cyc(2);
    Reset = 1'b0;

    // Reset state, then idle in BLANK
    check("rst_sel", 7'(sel), 7'd0);
    check("rst_tick", 7'(tick), 7'd0);
    check_hex("rst", S_OFF, S_OFF, S_OFF, S_OFF);
    cyc(5);
    check("idle_sel", 7'(sel), 7'd0);
    check("idle_tick", 7'(tick), 7'd0);
    check_hex("idle", S_OFF, S_OFF, S_OFF, S_OFF);

    // Step pulse leaves BLANK without advancing; HEX follows one cycle later
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("wake_sel", 7'(sel), 7'd0);
    check_hex("wake_pre", S_OFF, S_OFF, S_OFF, S_OFF);
    cyc();
    check_hex("wake", S_D, S_E, S_1, S_OFF);

    // Auto rotation left: tick after edges 4,8,12,16; sel steps one edge later
    run = 1'b1; dir = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      cyc();
      check($sformatf("auto_tick_e%0d", e), 7'(tick), 7'((e % 4) == 0));
      check($sformatf("auto_sel_e%0d", e), 7'(sel), 7'(((e - 1) / 4) % 4));
      if (e == 6) check_hex("auto_sel1", S_E, S_1, S_OFF, S_D);
    end

    // Paused, held step, direction right: single advance 0 -> 3, no ticks
    run = 1'b0; dir = 1'b1; step = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      check($sformatf("hold_sel_e%0d", e), 7'(sel), 7'd3);
      check($sformatf("hold_tick_e%0d", e), 7'(tick), 7'd0);
    end
    step = 1'b0;
    cyc(2);
    check("hold_end_sel", 7'(sel), 7'd3);
    check_hex("hold_end", S_OFF, S_D, S_E, S_1);

    // Running: step edge between ticks is ignored; wrap 3 -> 0 on tick
    run = 1'b1; dir = 1'b0;
    cyc(2);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("run_step_sel", 7'(sel), 7'd3);
    cyc();
    check("run_step_tick", 7'(tick), 7'd1);
    check("run_step_sel2", 7'(sel), 7'd3);
    cyc();
    check("run_wrap_sel", 7'(sel), 7'd0);
    cyc();

    // Reset mid-count with run still high
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("mid_rst_sel", 7'(sel), 7'd0);
    check("mid_rst_tick", 7'(tick), 7'd0);
    check_hex("mid_rst", S_OFF, S_OFF, S_OFF, S_OFF);
    cyc();
    check_hex("mid_rst_g8", S_OFF, S_OFF, S_OFF, S_OFF);
    check("cnt_restart_g8", 7'(tick), 7'd0);
    cyc();
    check("cnt_restart_g9", 7'(tick), 7'd0);
    check_hex("mid_rst_show", S_D, S_E, S_1, S_OFF);
    cyc();
    check("cnt_restart_g10", 7'(tick), 7'd0);
    cyc();
    check("cnt_restart_g11", 7'(tick), 7'd1);
    cyc();
    check("cnt_restart_sel", 7'(sel), 7'd1);

    // Back to sel=0 by a right step, then change C0 and see HEX0 one cycle later
    run = 1'b0; dir = 1'b1; step = 1'b1;
    cyc();
    step = 1'b0;
    check("c0_sel", 7'(sel), 7'd0);
    cyc();
    check("c0_before", HEX0, S_OFF);
    C0 = 2'b01;
    cyc();
    check("c0_after", HEX0, S_E);
    check("c0_hex3", HEX3, S_D);
    check("c0_sel_hold", 7'(sel), 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
